// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: register map, CTRL bit
// positions, ID version and the byte-strobe write merge.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_PRESC   = 2'd1,
        REG_COUNT   = 2'd2,
        REG_COMPARE = 2'd3
    } reg_off_e;

    localparam logic [4:0] ADDR_STATUS = 5'd16;
    localparam logic [4:0] ADDR_ID     = 5'd17;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IE      = 2;

    localparam logic [7:0] ID_VERSION = 8'h01;

    // Channel slots addressable by the 2-bit channel field of the word address.
    localparam int MAX_CH = 4;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: CTRL/PRESC/COUNT/COMPARE registers, enable-based
// prescaler, up-counter with compare match and the sticky match flag.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_ctrl,
    input  logic        we_presc,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wdata,
    input  logic        flag_clr,
    output logic [31:0] ctrl_rd,
    output logic [31:0] presc_rd,
    output logic [31:0] count_rd,
    output logic [31:0] compare_rd,
    output logic        flag,
    output logic        ie
);

    logic               en;
    logic               oneshot;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   compare;
    logic               presc_tick;
    logic               tick;
    logic               match;

    // A software write to COUNT swallows a coincident tick (and its match).
    assign presc_tick = en && (presc_cnt == presc);
    assign tick       = presc_tick && !we_count;
    assign match      = tick && (count == compare);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        ctrl_rd               = '0;
        ctrl_rd[CTRL_EN]      = en;
        ctrl_rd[CTRL_ONESHOT] = oneshot;
        ctrl_rd[CTRL_IE]      = ie;
    end

    assign presc_rd   = 32'(presc);
    assign count_rd   = 32'(count);
    assign compare_rd = 32'(compare);

    // NOTE: reset here is synchronous and active-low, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            en        <= 1'b0;
            oneshot   <= 1'b0;
            ie        <= 1'b0;
            presc     <= '0;
            presc_cnt <= '0;
            count     <= '0;
            compare   <= '0;
            flag      <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
            if (!en || we_presc || presc_tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end

            if (we_presc) begin
                presc <= wdata[PRESC_W-1:0];
            end
            if (we_compare) begin
                compare <= wdata[CNT_W-1:0];
            end

            if (we_count) begin
                count <= wdata[CNT_W-1:0];
            end else if (match) begin
                count <= '0;
            end else if (tick) begin
                count <= count + CNT_W'(1);
            end

            // The written EN overrides a one-shot auto-clear in the same cycle.
            if (we_ctrl) begin
                en      <= wdata[CTRL_EN];
                oneshot <= wdata[CTRL_ONESHOT];
                ie      <= wdata[CTRL_IE];
            end else if (match && oneshot) begin
                en <= 1'b0;
            end

            if (match) begin
                flag <= 1'b1;
            end else if (flag_clr) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped multi-channel timer: bus handshake, address decode, read mux,
// STATUS write-1-to-clear and the combined registered interrupt.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  reg_we,
    input  logic [3:0]  reg_re,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] reg_di,
    output logic [31:0] reg_do,
    output logic        ready,
    output logic        irq
);

    localparam logic [31:0] ID_VALUE = {ID_VERSION, 8'(NUM_CH), 8'(CNT_W), 8'(PRESC_W)};

    logic              access;
    logic              wr;
    logic              status_clr;
    logic [1:0]        ch;
    reg_off_e          off;
    logic [31:0]       rdata;
    logic [31:0]       wdata;
    logic [31:0]       rd_val [MAX_CH][4];
    logic [MAX_CH-1:0] flags;
    logic [MAX_CH-1:0] ie_bits;

    // A request is acknowledged only when ready is low, so a held strobe is
    // answered every other cycle.
    assign access     = ((reg_we != 4'd0) || (reg_re != 4'd0)) && !ready;
    assign wr         = access && (reg_we != 4'd0);
    assign status_clr = wr && (reg_addr == ADDR_STATUS) && reg_we[0];
    assign ch         = reg_addr[3:2];
    assign off        = reg_off_e'(reg_addr[1:0]);

    always_comb begin
        rdata = '0;
        if (!reg_addr[4]) begin
            rdata = rd_val[ch][reg_addr[1:0]];
        end else if (reg_addr == ADDR_STATUS) begin
            rdata = 32'(flags);
        end else if (reg_addr == ADDR_ID) begin
            rdata = ID_VALUE;
        end
    end

    // The addressed word's current value is both the read data and the base
    // for the byte-strobe merge.
    assign wdata = byte_merge(rdata, reg_di, reg_we);

    for (genvar c = 0; c < MAX_CH; c++) begin : g_ch
        if (c < NUM_CH) begin : g_impl
            logic sel;
            assign sel = wr && !reg_addr[4] && (ch == 2'(c));

            timer_channel #(
                .CNT_W   (CNT_W),
                .PRESC_W (PRESC_W)
            ) u_channel (
                .clk        (clk),
                .resetn     (resetn),
                .we_ctrl    (sel && (off == REG_CTRL)),
                .we_presc   (sel && (off == REG_PRESC)),
                .we_count   (sel && (off == REG_COUNT)),
                .we_compare (sel && (off == REG_COMPARE)),
                .wdata      (wdata),
                .flag_clr   (status_clr && reg_di[c]),
                .ctrl_rd    (rd_val[c][0]),
                .presc_rd   (rd_val[c][1]),
                .count_rd   (rd_val[c][2]),
                .compare_rd (rd_val[c][3]),
                .flag       (flags[c]),
                .ie         (ie_bits[c])
            );
        end else begin : g_none
            assign rd_val[c][0] = '0;
            assign rd_val[c][1] = '0;
            assign rd_val[c][2] = '0;
            assign rd_val[c][3] = '0;
            assign flags[c]     = 1'b0;
            assign ie_bits[c]   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready  <= 1'b0;
            reg_do <= '0;
            irq    <= 1'b0;
        end else begin
            ready  <= access;
            reg_do <= access ? rdata : '0;
            irq    <= |(flags & ie_bits);
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer; expected counter/flag values come from
// closed-form tick arithmetic on the edge at which a channel was enabled.
module tb_multi_timer;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b0;
    logic [3:0]  reg_we   = 4'd0;
    logic [3:0]  reg_re   = 4'd0;
    logic [4:0]  reg_addr = 5'd0;
    logic [31:0] reg_di   = 32'd0;
    logic [31:0] reg_do;
    logic        ready;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_edge = 0;

    localparam logic [31:0] ID_EXP = 32'h0102_2010;

    multi_timer #(
        .NUM_CH  (2),
        .CNT_W   (32),
        .PRESC_W (16)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_addr (reg_addr),
        .reg_di   (reg_di),
        .reg_do   (reg_do),
        .ready    (ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    // Ticks applied by edge e for a channel enabled at edge e0 with prescale p.
    function automatic int ticks_at(input int e, input int e0, input int p);
        return (e - e0) / (p + 1);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        total++;
        if (cyc > t) begin
            bad++;
            $display("FAIL wait_until: cycle=%0d required<=%0d", cyc, t);
        end
        while (cyc < t) step(1);
    endtask

    // One bus access: strobes sampled at the next edge, ready expected right after.
    task automatic bus(input logic [3:0] we, input logic [3:0] re, input int addr,
                       input logic [31:0] di, output logic [31:0] rd);
        reg_we   = we;
        reg_re   = re;
        reg_addr = 5'(addr);
        reg_di   = di;
        @(posedge clk);
        #1;
        last_edge = cyc;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL bus_ready addr=%0d: got=%b want=1", addr, ready);
        end
        rd     = reg_do;
        reg_we = 4'd0;
        reg_re = 4'd0;
        step(1);
    endtask

    task automatic reg_write(input int addr, input logic [31:0] data);
        logic [31:0] unused_rd;
        bus(4'hF, 4'h0, addr, data, unused_rd);
    endtask

    task automatic reg_read(input int addr, output logic [31:0] data);
        bus(4'h0, 4'hF, addr, 32'd0, data);
    endtask

    task automatic setup_ch(input int ch, input int p, input int c,
                            input logic [31:0] ctrl, output int e0);
        reg_write(4*ch, 32'd0);
        reg_write(16, 32'(1 << ch));
        reg_write(4*ch + 2, 32'd0);
        reg_write(4*ch + 1, 32'(p));
        reg_write(4*ch + 3, 32'(c));
        reg_write(4*ch, ctrl);
        e0 = last_edge;
    endtask

    task automatic check_all_words(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        for (int a = 0; a < 18; a++) begin
            reg_read(a, d);
            exp = (a == 17) ? ID_EXP : 32'd0;
            total++;
            if (d !== exp) begin
                bad++;
                $display("FAIL %s word%0d: got=%h want=%h", tag, a, d, exp);
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        step(3);
        resetn = 1'b1;
        step(1);
        total++;
        if ({ready, irq, reg_do} !== 34'd0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b irq=%b do=%h want all 0", ready, irq, reg_do);
        end
        check_all_words("reset_read");
    endtask

    task automatic test_periodic;
        int e0;
        logic [31:0] d;
        logic exp_irq;
        setup_ch(0, 0, 4, 32'h5, e0);
        for (int i = 0; i < 12; i++) begin
            exp_irq = ticks_at(cyc - 1, e0, 0) >= 5;
            total++;
            if (irq !== exp_irq) begin
                bad++;
                $display("FAIL periodic_irq t=%0d: got=%b want=%b", cyc - e0, irq, exp_irq);
            end
            step(1);
        end
        for (int i = 0; i < 6; i++) begin
            step($urandom_range(0, 3));
            reg_read(2, d);
            total++;
            if (d !== 32'(ticks_at(last_edge - 1, e0, 0) % 5)) begin
                bad++;
                $display("FAIL periodic_count: got=%0d want=%0d", d, ticks_at(last_edge - 1, e0, 0) % 5);
            end
        end
        reg_write(0, 32'h4);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_before_clear: got=%b want=1", irq);
        end
        reg_write(16, 32'h1);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_after_clear: got=%b want=0", irq);
        end
    endtask

    task automatic test_oneshot;
        int e0;
        logic [31:0] d;
        setup_ch(1, 3, 2, 32'h3, e0);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (irq !== 1'b0) begin
                bad++;
                $display("FAIL oneshot_irq t=%0d: got=%b want=0", cyc - e0, irq);
            end
            step(1);
        end
        reg_read(4, d);
        total++;
        if (d !== 32'h2) begin
            bad++;
            $display("FAIL oneshot_ctrl: got=%h want=00000002", d);
        end
        reg_read(6, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL oneshot_count: got=%h want=0", d);
        end
        reg_read(16, d);
        total++;
        if (d !== 32'h2) begin
            bad++;
            $display("FAIL oneshot_status: got=%h want=00000002", d);
        end
        step(9);
        reg_read(6, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL oneshot_count_hold: got=%h want=0", d);
        end
    endtask

    task automatic test_byte_strobe;
        logic [31:0] d, old_v, new_v, exp;
        logic [3:0]  s;
        reg_write(0, 32'h0);
        reg_write(2, 32'hAAAA_AAAA);
        bus(4'b0001, 4'h0, 2, 32'h0000_1234, d);
        reg_read(2, d);
        total++;
        if (d !== 32'hAAAA_AA34) begin
            bad++;
            $display("FAIL strobe_count: got=%h want=aaaaaa34", d);
        end
        for (int i = 0; i < 4; i++) begin
            old_v = $urandom;
            new_v = $urandom;
            s     = 4'($urandom_range(0, 15));
            exp   = old_v;
            if (s[0]) exp[7:0]   = new_v[7:0];
            if (s[1]) exp[15:8]  = new_v[15:8];
            if (s[2]) exp[23:16] = new_v[23:16];
            if (s[3]) exp[31:24] = new_v[31:24];
            reg_write(3, old_v);
            bus(s, 4'hF, 3, new_v, d);
            total++;
            if (d !== old_v) begin
                bad++;
                $display("FAIL rw_prewrite: got=%h want=%h", d, old_v);
            end
            reg_read(3, d);
            total++;
            if (d !== exp) begin
                bad++;
                $display("FAIL strobe_compare s=%b: got=%h want=%h", s, d, exp);
            end
        end
        reg_write(1, 32'hFFFF_FFFF);
        reg_read(1, d);
        total++;
        if (d !== 32'h0000_FFFF) begin
            bad++;
            $display("FAIL presc_width: got=%h want=0000ffff", d);
        end
        reg_write(1, 32'h0);
        reg_write(0, 32'hFFFF_FFF8);
        reg_read(0, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL ctrl_high_bits: got=%h want=0", d);
        end
        reg_write(8, 32'hFFFF_FFFF);
        reg_read(8, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL unimpl_channel: got=%h want=0", d);
        end
        reg_write(20, 32'hFFFF_FFFF);
        reg_read(20, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL unmapped: got=%h want=0", d);
        end
        reg_write(17, 32'h0);
        reg_read(17, d);
        total++;
        if (d !== ID_EXP) begin
            bad++;
            $display("FAIL id_readonly: got=%h want=%h", d, ID_EXP);
        end
    endtask

    task automatic test_count_write_race;
        int e0;
        logic [31:0] d;
        setup_ch(0, 0, 1000, 32'h1, e0);
        step(3);
        reg_write(2, 32'h50);
        reg_read(2, d);
        total++;
        if (d !== 32'h51) begin
            bad++;
            $display("FAIL count_write_vs_tick: got=%h want=00000051", d);
        end
        reg_write(0, 32'h0);
    endtask

    task automatic test_freeze;
        int e0, ed, e1, frozen;
        logic [31:0] d;
        for (int it = 0; it < 2; it++) begin
            setup_ch(0, 3, 1000, 32'h1, e0);
            step($urandom_range(5, 20));
            reg_write(0, 32'h0);
            ed     = last_edge;
            frozen = ticks_at(ed, e0, 3);
            step($urandom_range(0, 5));
            reg_read(2, d);
            total++;
            if (d !== 32'(frozen)) begin
                bad++;
                $display("FAIL freeze_count: got=%0d want=%0d", d, frozen);
            end
            reg_write(0, 32'h1);
            e1 = last_edge;
            wait_until(e1 + 3);
            reg_read(2, d);
            total++;
            if (d !== 32'(frozen)) begin
                bad++;
                $display("FAIL reenable_early: got=%0d want=%0d", d, frozen);
            end
            wait_until(e1 + 5);
            reg_read(2, d);
            total++;
            if (d !== 32'(frozen + 1)) begin
                bad++;
                $display("FAIL reenable_first_tick: got=%0d want=%0d", d, frozen + 1);
            end
        end
        reg_write(0, 32'h0);
    endtask

    task automatic test_w1c_race;
        int e0;
        logic [31:0] d;
        setup_ch(0, 1, 2, 32'h1, e0);
        wait_until(e0 + 11);
        reg_write(16, 32'h1);
        reg_read(16, d);
        total++;
        if (d[0] !== 1'b1) begin
            bad++;
            $display("FAIL w1c_vs_match: got=%b want=1", d[0]);
        end
        wait_until(e0 + 15);
        reg_write(16, 32'h1);
        reg_read(16, d);
        total++;
        if (d[0] !== 1'b0) begin
            bad++;
            $display("FAIL w1c_plain: got=%b want=0", d[0]);
        end
        reg_write(0, 32'h0);
    endtask

    task automatic test_oneshot_ctrl_race;
        int e0;
        logic [31:0] d;
        setup_ch(1, 0, 3, 32'h3, e0);
        wait_until(e0 + 3);
        reg_write(4, 32'h7);
        reg_read(4, d);
        total++;
        if (d !== 32'h7) begin
            bad++;
            $display("FAIL ctrl_vs_autoclear: got=%h want=00000007", d);
        end
        reg_write(4, 32'h0);
        reg_write(16, 32'h3);
    endtask

    task automatic test_random;
        int e0, p, c, t;
        logic [31:0] d;
        for (int it = 0; it < 6; it++) begin
            p = $urandom_range(0, 3);
            c = $urandom_range(0, 5);
            setup_ch(0, p, c, 32'h1, e0);
            for (int r = 0; r < 6; r++) begin
                step($urandom_range(0, 6));
                if ($urandom_range(0, 1) == 1) begin
                    reg_read(2, d);
                    t = ticks_at(last_edge - 1, e0, p);
                    total++;
                    if (d !== 32'(t % (c + 1))) begin
                        bad++;
                        $display("FAIL rand_count p=%0d c=%0d: got=%0d want=%0d", p, c, d, t % (c + 1));
                    end
                end else begin
                    reg_read(16, d);
                    t = ticks_at(last_edge - 1, e0, p);
                    total++;
                    if (d[0] !== (t >= c + 1)) begin
                        bad++;
                        $display("FAIL rand_flag p=%0d c=%0d: got=%b want=%b", p, c, d[0], t >= c + 1);
                    end
                end
            end
        end
        reg_write(0, 32'h0);
    endtask

    task automatic test_handshake;
        reg_re   = 4'hF;
        reg_addr = 5'd17;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_ready0: got=%b want=0", ready);
        end
        step(1);
        total++;
        if (ready !== 1'b1 || reg_do !== ID_EXP) begin
            bad++;
            $display("FAIL hold_ready1: got=%b/%h want=1/%h", ready, reg_do, ID_EXP);
        end
        step(1);
        total++;
        if (ready !== 1'b0 || reg_do !== 32'd0) begin
            bad++;
            $display("FAIL hold_ready2: got=%b/%h want=0/0", ready, reg_do);
        end
        step(1);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_ready3: got=%b want=1", ready);
        end
        reg_re = 4'h0;
        step(1);
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: got=%b want=0", ready);
        end
    endtask

    task automatic test_reset_mid_access;
        int e0;
        setup_ch(0, 0, 2, 32'h5, e0);
        step(10);
        reg_we   = 4'hF;
        reg_addr = 5'd3;
        reg_di   = 32'h77;
        resetn   = 1'b0;
        step(1);
        total++;
        if ({ready, irq, reg_do} !== 34'd0) begin
            bad++;
            $display("FAIL reset_abort: ready=%b irq=%b do=%h want all 0", ready, irq, reg_do);
        end
        reg_we = 4'h0;
        step(1);
        resetn = 1'b1;
        step(1);
        check_all_words("reset_mid");
    endtask

    initial begin
        test_reset;
        test_periodic;
        test_oneshot;
        test_byte_strobe;
        test_count_write_race;
        test_freeze;
        test_w1c_race;
        test_oneshot_ctrl_race;
        test_random;
        test_handshake;
        test_reset_mid_access;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
